// File: rtl/pipe_pkg.sv
// Shared types and constants for pipeline segment registers.
// Optional feature macro used by users of this package: PIPE_PERF_EN.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

    localparam int PERF_W = 32;

    localparam logic [31:0] PIPE_FLUSH_DEF = 32'h0000_0000;

endpackage

// File: rtl/pipe_entry.sv
// One storage entry (valid, taken, data) of a pipeline segment register.
// Clear forces the idle value FLUSH_VAL/0/0; load captures a valid item.
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] FLUSH_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              i_clr,
    input  logic              i_ld,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_taken,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_taken
);

    logic [DATA_W+1:0] r_ent;

    // Clear dominates load; otherwise the entry holds its contents.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_ent <= {1'b0, 1'b0, FLUSH_VAL};
        end else if (i_ld) begin
            r_ent <= {1'b1, i_taken, i_data};
        end
    end

    assign o_valid = r_ent[DATA_W+1];
    assign o_taken = r_ent[DATA_W];
    assign o_data  = r_ent[DATA_W-1:0];

endmodule

// File: rtl/pipe_seg_reg.sv
// Pipeline segment register with 2-entry skid, bubble hold and flush.
// Define PIPE_PERF_EN to add the saturating stall_cnt output.
module pipe_seg_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] FLUSH_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_taken,
    input  logic              bubble,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_taken
`ifdef PIPE_PERF_EN
    ,
    output logic [PERF_W-1:0] stall_cnt
`endif
);

    pipe_state_e       r_state;
    pipe_state_e       w_state_nxt;

    logic              w_accept;
    logic              w_drain;
    logic              w_main_ld;
    logic              w_main_clr;
    logic              w_main_src_skid;
    logic              w_skid_ld;
    logic              w_skid_clr;

    logic              w_main_valid;
    logic              w_skid_valid;
    logic [DATA_W-1:0] w_skid_data;
    logic              w_skid_taken;
    logic [DATA_W-1:0] w_main_d;
    logic              w_main_t;

    assign in_ready = ~w_skid_valid & ~bubble & ~rst;
    assign w_accept = in_valid & in_ready;
    assign w_drain  = w_main_valid & out_ready & ~bubble;

    assign w_main_d = w_main_src_skid ? w_skid_data  : in_data;
    assign w_main_t = w_main_src_skid ? w_skid_taken : in_taken;

    // State register; reset and flush both return to EMPTY.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and entry controls; squash overrides the normal moves.
    always_comb begin
        w_state_nxt     = r_state;
        w_main_ld       = 1'b0;
        w_main_clr      = 1'b0;
        w_main_src_skid = 1'b0;
        w_skid_ld       = 1'b0;
        w_skid_clr      = 1'b0;
        unique case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_main_ld   = 1'b1;
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_accept && w_drain) begin
                    w_main_ld   = 1'b1;
                end else if (w_accept) begin
                    w_skid_ld   = 1'b1;
                    w_state_nxt = ST_SKID;
                end else if (w_drain) begin
                    w_main_clr  = 1'b1;
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (w_drain) begin
                    w_main_ld       = 1'b1;
                    w_main_src_skid = 1'b1;
                    w_skid_clr      = 1'b1;
                    w_state_nxt     = ST_FULL;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
        if (rst || flush) begin
            w_main_ld   = 1'b0;
            w_skid_ld   = 1'b0;
            w_main_clr  = 1'b1;
            w_skid_clr  = 1'b1;
            w_state_nxt = ST_EMPTY;
        end
    end

    pipe_entry #(
        .DATA_W    (DATA_W),
        .FLUSH_VAL (FLUSH_VAL)
    ) u_main (
        .clk     (clk),
        .i_clr   (w_main_clr),
        .i_ld    (w_main_ld),
        .i_data  (w_main_d),
        .i_taken (w_main_t),
        .o_valid (w_main_valid),
        .o_data  (out_data),
        .o_taken (out_taken)
    );

    pipe_entry #(
        .DATA_W    (DATA_W),
        .FLUSH_VAL (FLUSH_VAL)
    ) u_skid (
        .clk     (clk),
        .i_clr   (w_skid_clr),
        .i_ld    (w_skid_ld),
        .i_data  (in_data),
        .i_taken (in_taken),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data),
        .o_taken (w_skid_taken)
    );

    assign out_valid = w_main_valid;

`ifdef PIPE_PERF_EN
    logic [PERF_W-1:0] r_stall;

    // Count cycles an item waits; saturates, survives flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall <= '0;
        end else if (w_main_valid && (!out_ready || bubble) && !(&r_stall)) begin
            r_stall <= r_stall + 1'b1;
        end
    end

    assign stall_cnt = r_stall;
`endif

endmodule

// File: tb/tb_pipe_seg_reg.sv
// Directed self-checking bench for pipe_seg_reg.
// Stall counter checks are compiled in with PIPE_PERF_EN.
module tb_pipe_seg_reg;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_taken;
    logic        bubble;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_taken;
`ifdef PIPE_PERF_EN
    logic [PERF_W-1:0] stall_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pipe_seg_reg #(
        .DATA_W    (32),
        .FLUSH_VAL (32'h0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_taken  (in_taken),
        .bubble    (bubble),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_taken (out_taken)
`ifdef PIPE_PERF_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs, check outputs mid-cycle, then clock.
    task automatic vec(input string tag, input logic r, input logic iv,
                       input logic [31:0] d, input logic t,
                       input logic ordy, input logic bub, input logic fl,
                       input logic eir, input logic eov,
                       input logic [31:0] eod, input logic eot);
        rst       = r;
        in_valid  = iv;
        in_data   = d;
        in_taken  = t;
        out_ready = ordy;
        bubble    = bub;
        flush     = fl;
        #1;
        check({tag, ".in_ready"},  {63'd0, in_ready},  {63'd0, eir});
        check({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, eov});
        check({tag, ".out_data"},  {32'd0, out_data},  {32'd0, eod});
        check({tag, ".out_taken"}, {63'd0, out_taken}, {63'd0, eot});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD_BEEF;
        in_taken  = 1'b1;
        out_ready = 1'b1;
        bubble    = 1'b0;
        flush     = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst.out_valid", {63'd0, out_valid}, 64'd0);
        check("rst.out_data",  {32'd0, out_data},  64'd0);
        check("rst.out_taken", {63'd0, out_taken}, 64'd0);
        check("rst.in_ready",  {63'd0, in_ready},  64'd0);
`ifdef PIPE_PERF_EN
        check("rst.stall_cnt", {32'd0, stall_cnt}, 64'd0);
`endif
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("post_rst.in_ready", {63'd0, in_ready}, 64'd1);

        // streaming
        //  tag    r  iv d            t  or bb fl  eir eov eod         eot
        vec("s1", 0, 1, 32'h0,       0, 1, 0, 0,  1,  0,  32'h0,      0);
        vec("s2", 0, 1, 32'h4,       1, 1, 0, 0,  1,  1,  32'h0,      0);
        vec("s3", 0, 1, 32'h8,       1, 1, 0, 0,  1,  1,  32'h4,      1);
        vec("s4", 0, 1, 32'hC,       0, 1, 0, 0,  1,  1,  32'h8,      1);
        vec("s5", 0, 0, 32'h0,       0, 1, 0, 0,  1,  1,  32'hC,      0);
        vec("s6", 0, 0, 32'h0,       0, 1, 0, 0,  1,  0,  32'h0,      0);

        // backpressure
        vec("b1", 0, 1, 32'h100,     0, 1, 0, 0,  1,  0,  32'h0,      0);
        vec("b2", 0, 1, 32'h104,     0, 1, 0, 0,  1,  1,  32'h100,    0);
        vec("b3", 0, 1, 32'h108,     0, 0, 0, 0,  1,  1,  32'h104,    0);
        vec("b4", 0, 1, 32'h10C,     0, 0, 0, 0,  0,  1,  32'h104,    0);
        vec("b5", 0, 1, 32'h10C,     0, 0, 0, 0,  0,  1,  32'h104,    0);
        vec("b6", 0, 1, 32'h10C,     0, 1, 0, 0,  0,  1,  32'h104,    0);
        vec("b7", 0, 1, 32'h10C,     0, 1, 0, 0,  1,  1,  32'h108,    0);
        vec("b8", 0, 0, 32'h0,       0, 1, 0, 0,  1,  1,  32'h10C,    0);
        vec("b9", 0, 0, 32'h0,       0, 1, 0, 0,  1,  0,  32'h0,      0);

        // bubble hold
        vec("h1", 0, 1, 32'h200,     1, 0, 0, 0,  1,  0,  32'h0,      0);
        vec("h2", 0, 1, 32'h204,     0, 1, 1, 0,  0,  1,  32'h200,    1);
        vec("h3", 0, 1, 32'h204,     0, 1, 1, 0,  0,  1,  32'h200,    1);
        vec("h4", 0, 1, 32'h204,     0, 1, 1, 0,  0,  1,  32'h200,    1);
        vec("h5", 0, 0, 32'h0,       0, 1, 0, 0,  1,  1,  32'h200,    1);
        vec("h6", 0, 0, 32'h0,       0, 1, 0, 0,  1,  0,  32'h0,      0);

        // flush beats bubble, flush vs accept, flush vs drain
        vec("f1", 0, 1, 32'h300,     0, 0, 0, 0,  1,  0,  32'h0,      0);
        vec("f2", 0, 1, 32'h304,     1, 0, 0, 0,  1,  1,  32'h300,    0);
        vec("f3", 0, 1, 32'h308,     1, 1, 1, 1,  0,  1,  32'h300,    0);
        vec("f4", 0, 1, 32'h30C,     0, 0, 0, 0,  1,  0,  32'h0,      0);
        vec("f5", 0, 0, 32'h0,       0, 1, 0, 0,  1,  1,  32'h30C,    0);
        vec("f6", 0, 1, 32'h400,     1, 1, 0, 1,  1,  0,  32'h0,      0);
        vec("f7", 0, 1, 32'h500,     1, 1, 0, 0,  1,  0,  32'h0,      0);
        vec("f8", 0, 0, 32'h0,       0, 1, 0, 1,  1,  1,  32'h500,    1);
        vec("f9", 0, 0, 32'h0,       0, 1, 0, 0,  1,  0,  32'h0,      0);

        // reset mid-operation
        vec("m1", 0, 1, 32'h600,     1, 0, 0, 0,  1,  0,  32'h0,      0);
        vec("m2", 1, 1, 32'h604,     1, 0, 0, 0,  0,  1,  32'h600,    1);
        vec("m3", 0, 0, 32'h0,       0, 0, 0, 0,  1,  0,  32'h0,      0);

        // stall run: 10 cycles blocked, then flush while draining
        vec("p0", 1, 0, 32'h0,       0, 1, 0, 0,  0,  0,  32'h0,      0);
        vec("p1", 0, 1, 32'h700,     1, 0, 0, 0,  1,  0,  32'h0,      0);
        for (int i = 0; i < 10; i++) begin
            vec("p_hold", 0, 0, 32'h0, 0, 0, 0, 0, 1, 1, 32'h700, 1);
        end
`ifdef PIPE_PERF_EN
        check("perf.after_hold", {32'd0, stall_cnt}, 64'd10);
`endif
        vec("p2", 0, 0, 32'h0,       0, 1, 0, 1,  1,  1,  32'h700,    1);
        vec("p3", 0, 0, 32'h0,       0, 1, 0, 0,  1,  0,  32'h0,      0);
`ifdef PIPE_PERF_EN
        check("perf.after_flush", {32'd0, stall_cnt}, 64'd10);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_seg_reg.md
# pipe_seg_reg

Parametrised pipeline segment register: the next generation of the per-stage PC/prediction registers between IF/ID, ID/EX and later stages. It carries a DATA_W payload plus a branch-predict bit from one stage to the next, with a valid/ready handshake. A 2-entry skid buffer keeps throughput at one item per cycle even though `in_ready` is registered. It also supports hazard-unit `bubble` (hold) and `flush` (squash), and has an optional stall counter.

## Interface
Parameters:
- DATA_W, 32, payload width (PC or any stage field bundle)
- FLUSH_VAL, {DATA_W{1'b0}}, value driven on `out_data` after reset/flush

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- in_valid  in  1  upstream item present
- in_ready  out  1  stage can accept this cycle
- in_data  in  DATA_W  upstream payload
- in_taken  in  1  upstream branch-predict result
- bubble  in  1  hazard-unit hold: freeze all state
- flush  in  1  hazard-unit squash: discard all held items
- out_valid  out  1  downstream item present
- out_ready  in  1  downstream can accept
- out_data  out  DATA_W  payload to next stage
- out_taken  out  1  predict bit to next stage
- stall_cnt  out  32  stall cycle counter (present only with PIPE_PERF_EN)

## Operation
- Storage: main entry (drives `out_*`) and skid entry. Each entry holds valid, data and taken.
- States: EMPTY (no valid entries), FULL (main only), SKID (main and skid).
- accept = in_valid & in_ready. drain = out_valid & out_ready & ~bubble.
- in_ready = ~skid_valid & ~bubble & ~rst. This is the only combinational path, and it comes from `bubble`/`rst`.
- Transitions:
  - EMPTY: accept -> FULL (main <= in).
  - FULL: accept & drain -> FULL (main <= in). accept & ~drain -> SKID (skid <= in). ~accept & drain -> EMPTY.
  - SKID: drain -> FULL (main <= skid, skid cleared). Otherwise hold.
- `bubble`: no accept, no drain. All entries hold their values.
- `flush`: on the next edge, both entries become invalid, main data becomes FLUSH_VAL and main taken becomes 0. State becomes EMPTY. The incoming item that cycle is dropped.
- Priority: rst > flush > bubble > normal. Flush wins over bubble. This is deliberate; in the earlier stage registers, hold won.
- Invariants:
  - skid_valid implies main_valid.
  - Ordering is strictly FIFO.
  - An item is never both dropped and delivered.
- Invalid entries keep data = FLUSH_VAL and taken = 0. `out_data` is therefore deterministic whenever `out_valid` = 0.

## Timing
- Reset values: out_valid 0, out_data FLUSH_VAL, out_taken 0, stall_cnt 0. in_ready is 0 while rst is high and 1 on the first cycle after.
- Latency: an item accepted at edge N is visible on `out_*` after edge N, so a downstream transfer is possible at edge N+1.
- Throughput: 1 item/cycle sustained when out_ready = 1 and bubble = 0.
- Backpressure: after out_ready drops, at most one further item is absorbed (into skid). in_ready falls on the following cycle.
- Flush and accept in the same cycle: flush wins, and the stage is EMPTY next cycle.
- Flush and drain in the same cycle: the downstream transfer still completes that edge, then the stage is EMPTY.
- Reset asserted mid-operation clears all entries on the same edge as a flush would.

## Configuration
- PIPE_PERF_EN defined: `stall_cnt` exists. It increments each cycle where out_valid & (~out_ready | bubble), saturates at 32'hFFFF_FFFF, and is cleared only by rst (not by flush).
- PIPE_PERF_EN undefined: the `stall_cnt` port and counter logic are absent. All other behaviour is identical.

## Structure
- Shared package `pipe_pkg`: state enum (ST_EMPTY, ST_FULL, ST_SKID), the counter width constant PERF_W = 32, and the default flush value.
- One sub-module, `pipe_entry`: a DATA_W+2 register with load, clear-to-FLUSH_VAL and hold controls. It is instantiated twice (main, skid).
- Control FSM and counter live in the top module.

## Test plan
- Reset: assert rst 2 cycles with in_valid = 1 -> out_valid 0, out_data 0, in_ready 0. On the first post-reset cycle in_ready = 1.
- Streaming: feed PCs 0x0, 0x4, 0x8, 0xC with out_ready = 1 -> same sequence on `out_data`, 1 cycle latency, no gaps. out_taken follows in_taken.
- Backpressure: stream 0x100, 0x104, 0x108, 0x10C with out_ready low for cycles 2–4 -> skid holds 0x108 and in_ready drops. After release, output is 0x100, 0x104, 0x108, 0x10C with none lost or duplicated.
- Bubble: bubble high for 3 cycles with main = 0x200 -> out_data stays 0x200, in_ready 0, no transfer even with out_ready = 1.
- Flush beats bubble: SKID state (0x300/0x304) with flush = 1 and bubble = 1 in the same cycle -> next cycle out_valid 0, out_data FLUSH_VAL, out_taken 0, in_ready 1.
- PIPE_PERF_EN: hold out_ready = 0 for 10 cycles with out_valid = 1 -> stall_cnt = 10. A subsequent flush leaves it at 10.
